execute_pipe: RTL and testbench
===============================

Name: execute_pipe

Overview:
Pipelined execute stage, successor to the single-cycle execute datapath. It contains the operand-forwarding muxes, branch/jump resolution, the ALU with extended ops, a parametrised multi-cycle multiplier, and the EX/MEM pipeline register. It sits between the ID/EX register and the memory stage. The register file and data memory are external. The hazard unit consumes busy_e and drives flush_e.

Parameters:
DATA_WIDTH, 32, datapath width
ADDRESS_WIDTH, 5, register index width
ALUCTRL_WIDTH, 4, ALU op code width
MUL_LATENCY, 4, extra cycles a MUL holds EX (0 = single-cycle multiply)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_e  in  1  EX holds a real instruction
flush_e  in  1  kill EX instruction this cycle
RegWrite_e, MemWrite_e, ALUsrc_e, Branch_e, Jump_e, JALRctrl_e  in  1 each  decoded controls
ResultSrc_e  in  2  00 ALU, 01 load, 10 PC+4
ALUctrl_e  in  ALUCTRL_WIDTH  ALU op (exec_pkg encoding)
funct3_e  in  3  branch condition
rs1_e, rs2_e, rd_e  in  ADDRESS_WIDTH  register indices
RD1_e, RD2_e, ImmOp_e, PC_e, PCPlus4_e  in  DATA_WIDTH  operands
rd_w  in  ADDRESS_WIDTH; RegWrite_w  in  1; Result_w  in  DATA_WIDTH  WB forwarding source
busy_e  out  1  multiply in progress; upstream must hold D/E
PCSrc_e  out  1  redirect fetch
PCTarget_e  out  DATA_WIDTH  redirect address
valid_m, RegWrite_m, MemWrite_m  out  1  EX/MEM register
ResultSrc_m  out  2; rd_m  out  ADDRESS_WIDTH
ALUResult_m, WriteData_m, PCPlus4_m  out  DATA_WIDTH

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. On reset: all _m outputs are 0, the multiply counter is 0, busy_e = 0.
- Forwarding is evaluated per source (rs1 → SrcA, rs2 → SrcB_reg) in this priority order:
  - MEM first, when valid_m & RegWrite_m & rd_m!=0 & rd_m==rs & ResultSrc_m!=01. The forwarded value is PCPlus4_m if ResultSrc_m==10, otherwise ALUResult_m.
  - WB second, when RegWrite_w & rd_w!=0 & rd_w==rs; the value is Result_w.
  - Otherwise the register-file value RD1_e/RD2_e.
  - A load in MEM is never forwarded; the hazard unit stalls that case.
- SrcB = ALUsrc_e ? ImmOp_e : SrcB_reg. WriteData is SrcB_reg.
- ALU ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB, MUL. Shift amount is SrcB[$clog2(DATA_WIDTH)-1:0]. MUL returns the low DATA_WIDTH bits.
- Branch conditions on SrcA/SrcB_reg by funct3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
- PCSrc_e = valid_e & !flush_e & (Jump_e | (Branch_e & cond)). This output is combinational.
- PCTarget_e = JALRctrl_e ? ((SrcA+ImmOp_e) & ~1) : PC_e+ImmOp_e.
- Multiply with MUL_LATENCY=L>0:
  - Cycle 0: a valid, unflushed MUL enters with the counter idle. Forwarded operands are captured, the counter is loaded with L, and busy_e=1 combinationally in that same cycle.
  - busy_e stays 1 through cycles 0..L-1. Each of those edges writes a bubble to EX/MEM.
  - In cycle L, busy_e=0 and the product is ready; EX/MEM captures it at the end of cycle L.
  - The product is computed only from the captured operands, so WB changes during the stall have no effect.
  - With L=0 the product is combinational and there is no stall.
- flush_e has priority over everything: it clears the counter, forces busy_e=0 in that cycle, and writes a bubble.
- Bubble = valid_m, RegWrite_m, MemWrite_m, ResultSrc_m, rd_m and all data fields set to 0.
- Otherwise each edge loads EX/MEM from EX, with valid_m = valid_e.
- A MUL issued back-to-back after a completed MUL starts a fresh count.
- rst mid-multiply aborts the multiply with no write.

Decomposition:
- exec_pkg holds:
  - alu_op_t enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASSB=10, MUL=11)
  - funct3 branch constants
  - ResultSrc constants (RES_ALU, RES_LOAD, RES_PC4)
- One sub-module, mul_unit: start/flush in, busy/product out, owns the counter and the operand capture. Forwarding, branch logic and the EX/MEM register stay in execute_pipe.

Test Plan:
1. Reset: rst=1 for 2 cycles with valid_e=1 → valid_m=0, RegWrite_m=0, MemWrite_m=0, busy_e=0.
2. MEM forward: addi x5,x0,7 then add x6,x5,x5 with RD1/RD2=0 → second ALUResult_m=14. A jal x5 in MEM forwards PCPlus4_m.
3. Priority: MEM holds x5=7 and WB holds x5=100 → SrcA=7. Writes to rd=0 on either path → SrcA=RD1_e.
4. Branch: blt with SrcA=0xFFFFFFFF, SrcB=1 → PCSrc_e=1, PCTarget_e=PC_e+ImmOp_e. bltu with the same operands → PCSrc_e=0. JALR with SrcA=0x1001, Imm=4 → PCTarget_e=0x1004.
5. MUL, L=4: 0x00010003*5 → busy_e=1 for 4 cycles and 4 bubbles, then ALUResult_m=0x0005000F. Change Result_w during the stall → same result.
6. flush_e in cycle 2 of a MUL → busy_e=0 that cycle, no write. Next instruction (add) completes normally; a later MUL counts the full 4 cycles.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the pipelined execute stage.
// ALU opcodes, branch funct3 values and result-source selects.
package exec_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    SLT   = 4'd5,
    SLTU  = 4'd6,
    SLL   = 4'd7,
    SRL   = 4'd8,
    SRA   = 4'd9,
    PASSB = 4'd10,
    MUL   = 4'd11
  } alu_op_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

endpackage

// File: rtl/execute_pipe_mul.sv
// Multi-cycle multiplier: captures operands on start and holds EX
// until the product of the captured operands is ready.
module mul_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CW =
    (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  w_idle;
  logic                  w_go;

  assign w_idle = (r_cnt == '0);
  assign w_go   = start & w_idle & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_cnt <= '0;
    end else if (w_go) begin
      r_cnt <= CW'(MUL_LATENCY);
      r_a   <= a;
      r_b   <= b;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Count of 1 is the result cycle: EX is released, product valid.
  assign busy = (MUL_LATENCY != 0) & ~rst & ~flush &
                (w_go | (r_cnt > CW'(1)));

  assign product = (MUL_LATENCY == 0) ? a * b : r_a * r_b;

endmodule

// File: rtl/execute_pipe.sv
// Pipelined execute stage: forwarding, ALU, branch resolution,
// multi-cycle multiply and the EX/MEM pipeline register.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUCTRL_WIDTH = 4,
  parameter int MUL_LATENCY   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_e,
  input  logic                     flush_e,
  input  logic                     RegWrite_e,
  input  logic                     MemWrite_e,
  input  logic                     ALUsrc_e,
  input  logic                     Branch_e,
  input  logic                     Jump_e,
  input  logic                     JALRctrl_e,
  input  logic [1:0]               ResultSrc_e,
  input  logic [ALUCTRL_WIDTH-1:0] ALUctrl_e,
  input  logic [2:0]               funct3_e,
  input  logic [ADDRESS_WIDTH-1:0] rs1_e,
  input  logic [ADDRESS_WIDTH-1:0] rs2_e,
  input  logic [ADDRESS_WIDTH-1:0] rd_e,
  input  logic [DATA_WIDTH-1:0]    RD1_e,
  input  logic [DATA_WIDTH-1:0]    RD2_e,
  input  logic [DATA_WIDTH-1:0]    ImmOp_e,
  input  logic [DATA_WIDTH-1:0]    PC_e,
  input  logic [DATA_WIDTH-1:0]    PCPlus4_e,
  input  logic [ADDRESS_WIDTH-1:0] rd_w,
  input  logic                     RegWrite_w,
  input  logic [DATA_WIDTH-1:0]    Result_w,
  output logic                     busy_e,
  output logic                     PCSrc_e,
  output logic [DATA_WIDTH-1:0]    PCTarget_e,
  output logic                     valid_m,
  output logic                     RegWrite_m,
  output logic                     MemWrite_m,
  output logic [1:0]               ResultSrc_m,
  output logic [ADDRESS_WIDTH-1:0] rd_m,
  output logic [DATA_WIDTH-1:0]    ALUResult_m,
  output logic [DATA_WIDTH-1:0]    WriteData_m,
  output logic [DATA_WIDTH-1:0]    PCPlus4_m
);

  localparam int SW = $clog2(DATA_WIDTH);

  logic                     r_valid;
  logic                     r_regwrite;
  logic                     r_memwrite;
  logic [1:0]               r_ressrc;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]    r_alu;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_pc4;

  alu_op_t               w_op;
  logic                  w_mem_ok;
  logic                  w_wb_ok;
  logic [DATA_WIDTH-1:0] w_mem_val;
  logic [DATA_WIDTH-1:0] w_srca;
  logic [DATA_WIDTH-1:0] w_srcb_reg;
  logic [DATA_WIDTH-1:0] w_srcb;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_jalr;
  logic [SW-1:0]         w_sh;
  logic                  w_cond;
  logic                  w_mul_start;

  assign w_op = alu_op_t'(ALUctrl_e[3:0]);

  // Loads in MEM have no data yet; the hazard unit stalls them.
  assign w_mem_ok = r_valid & r_regwrite & (r_rd != '0) &
                    (r_ressrc != RES_LOAD);
  assign w_wb_ok  = RegWrite_w & (rd_w != '0);
  assign w_mem_val = (r_ressrc == RES_PC4) ? r_pc4 : r_alu;

  assign w_srca =
    (w_mem_ok && r_rd == rs1_e) ? w_mem_val :
    (w_wb_ok && rd_w == rs1_e)  ? Result_w  : RD1_e;
  assign w_srcb_reg =
    (w_mem_ok && r_rd == rs2_e) ? w_mem_val :
    (w_wb_ok && rd_w == rs2_e)  ? Result_w  : RD2_e;
  assign w_srcb = ALUsrc_e ? ImmOp_e : w_srcb_reg;
  assign w_sh   = w_srcb[SW-1:0];

  assign w_mul_start = valid_e & ~flush_e & (w_op == MUL);

  mul_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_mul_start),
    .flush  (flush_e),
    .a      (w_srca),
    .b      (w_srcb),
    .busy   (busy_e),
    .product(w_prod)
  );

  always_comb begin
    w_alu = '0;
    unique case (w_op)
      ADD:   w_alu = w_srca + w_srcb;
      SUB:   w_alu = w_srca - w_srcb;
      AND:   w_alu = w_srca & w_srcb;
      OR:    w_alu = w_srca | w_srcb;
      XOR:   w_alu = w_srca ^ w_srcb;
      SLT:   w_alu = DATA_WIDTH'($signed(w_srca) < $signed(w_srcb));
      SLTU:  w_alu = DATA_WIDTH'(w_srca < w_srcb);
      SLL:   w_alu = w_srca << w_sh;
      SRL:   w_alu = w_srca >> w_sh;
      SRA:   w_alu = $unsigned($signed(w_srca) >>> w_sh);
      PASSB: w_alu = w_srcb;
      MUL:   w_alu = w_prod;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (funct3_e)
      F3_BEQ:  w_cond = (w_srca == w_srcb_reg);
      F3_BNE:  w_cond = (w_srca != w_srcb_reg);
      F3_BLT:  w_cond = $signed(w_srca) < $signed(w_srcb_reg);
      F3_BGE:  w_cond = $signed(w_srca) >= $signed(w_srcb_reg);
      F3_BLTU: w_cond = w_srca < w_srcb_reg;
      F3_BGEU: w_cond = w_srca >= w_srcb_reg;
      default: w_cond = 1'b0;
    endcase
  end

  assign PCSrc_e = valid_e & ~flush_e &
                   (Jump_e | (Branch_e & w_cond));
  assign w_jalr  = w_srca + ImmOp_e;
  assign PCTarget_e = JALRctrl_e ? {w_jalr[DATA_WIDTH-1:1], 1'b0}
                                 : PC_e + ImmOp_e;

  always_ff @(posedge clk) begin
    if (rst || flush_e || busy_e) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_ressrc   <= '0;
      r_rd       <= '0;
      r_alu      <= '0;
      r_wdata    <= '0;
      r_pc4      <= '0;
    end else begin
      r_valid    <= valid_e;
      r_regwrite <= RegWrite_e;
      r_memwrite <= MemWrite_e;
      r_ressrc   <= ResultSrc_e;
      r_rd       <= rd_e;
      r_alu      <= w_alu;
      r_wdata    <= w_srcb_reg;
      r_pc4      <= PCPlus4_e;
    end
  end

  assign valid_m     = r_valid;
  assign RegWrite_m  = r_regwrite;
  assign MemWrite_m  = r_memwrite;
  assign ResultSrc_m = r_ressrc;
  assign rd_m        = r_rd;
  assign ALUResult_m = r_alu;
  assign WriteData_m = r_wdata;
  assign PCPlus4_m   = r_pc4;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: forwarding, branches,
// multi-cycle multiply, flush and reset.
module tb_execute_pipe;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_e, flush_e, RegWrite_e, MemWrite_e;
  logic        ALUsrc_e, Branch_e, Jump_e, JALRctrl_e;
  logic [1:0]  ResultSrc_e;
  logic [3:0]  ALUctrl_e;
  logic [2:0]  funct3_e;
  logic [4:0]  rs1_e, rs2_e, rd_e, rd_w;
  logic [31:0] RD1_e, RD2_e, ImmOp_e, PC_e, PCPlus4_e;
  logic        RegWrite_w;
  logic [31:0] Result_w;
  logic        busy_e, PCSrc_e;
  logic [31:0] PCTarget_e;
  logic        valid_m, RegWrite_m, MemWrite_m;
  logic [1:0]  ResultSrc_m;
  logic [4:0]  rd_m;
  logic [31:0] ALUResult_m, WriteData_m, PCPlus4_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  execute_pipe dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
    .RegWrite_e(RegWrite_e), .MemWrite_e(MemWrite_e),
    .ALUsrc_e(ALUsrc_e), .Branch_e(Branch_e), .Jump_e(Jump_e),
    .JALRctrl_e(JALRctrl_e), .ResultSrc_e(ResultSrc_e),
    .ALUctrl_e(ALUctrl_e), .funct3_e(funct3_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .RD1_e(RD1_e), .RD2_e(RD2_e), .ImmOp_e(ImmOp_e),
    .PC_e(PC_e), .PCPlus4_e(PCPlus4_e),
    .rd_w(rd_w), .RegWrite_w(RegWrite_w), .Result_w(Result_w),
    .busy_e(busy_e), .PCSrc_e(PCSrc_e), .PCTarget_e(PCTarget_e),
    .valid_m(valid_m), .RegWrite_m(RegWrite_m),
    .MemWrite_m(MemWrite_m), .ResultSrc_m(ResultSrc_m),
    .rd_m(rd_m), .ALUResult_m(ALUResult_m),
    .WriteData_m(WriteData_m), .PCPlus4_m(PCPlus4_m)
  );

  task automatic clr();
    valid_e = 0; flush_e = 0; RegWrite_e = 0; MemWrite_e = 0;
    ALUsrc_e = 0; Branch_e = 0; Jump_e = 0; JALRctrl_e = 0;
    ResultSrc_e = RES_ALU; ALUctrl_e = ADD; funct3_e = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0;
    RD1_e = 0; RD2_e = 0; ImmOp_e = 0; PC_e = 0; PCPlus4_e = 0;
    rd_w = 0; RegWrite_w = 0; Result_w = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU-type instruction: rd = op(x[rs1], rs2 or imm)
  task automatic alu_instr(input logic [3:0] op,
                           input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic imm_sel,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm);
    valid_e = 1; RegWrite_e = 1; ALUctrl_e = op; rd_e = d;
    rs1_e = s1; rs2_e = s2; ALUsrc_e = imm_sel;
    RD1_e = a; RD2_e = b; ImmOp_e = imm;
    Jump_e = 0; Branch_e = 0; JALRctrl_e = 0;
    ResultSrc_e = RES_ALU;
  endtask

  task automatic test_reset();
    clr();
    rst = 1; valid_e = 1; RegWrite_e = 1; MemWrite_e = 1;
    ALUctrl_e = MUL;
    tick(); tick();
    total++;
    if (valid_m !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", valid_m);
    end
    total++;
    if (RegWrite_m !== 1'b0 || MemWrite_m !== 1'b0) begin
      bad++;
      $display("FAIL rst_wr got=%b%b exp=00", RegWrite_m, MemWrite_m);
    end
    total++;
    if (busy_e !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", busy_e);
    end
    rst = 0; clr(); tick();
  endtask

  task automatic test_mem_fwd();
    clr();
    alu_instr(ADD, 5, 0, 0, 1, 0, 0, 7);
    tick();
    alu_instr(ADD, 6, 5, 5, 0, 0, 0, 0);
    tick();
    total++;
    if (ALUResult_m !== 32'd14) begin
      bad++; $display("FAIL mem_fwd got=%h exp=%h", ALUResult_m, 32'd14);
    end
    clr();
    valid_e = 1; RegWrite_e = 1; Jump_e = 1; ResultSrc_e = RES_PC4;
    rd_e = 5; PC_e = 32'h100; PCPlus4_e = 32'h104; ImmOp_e = 32'h20;
    #1;
    total++;
    if (PCSrc_e !== 1'b1 || PCTarget_e !== 32'h120) begin
      bad++;
      $display("FAIL jal_redirect got=%b/%h exp=1/%h",
               PCSrc_e, PCTarget_e, 32'h120);
    end
    tick();
    clr();
    alu_instr(ADD, 7, 5, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (ALUResult_m !== 32'h104) begin
      bad++; $display("FAIL pc4_fwd got=%h exp=%h", ALUResult_m, 32'h104);
    end
    clr(); tick();
  endtask

  task automatic test_priority();
    clr();
    alu_instr(ADD, 5, 0, 0, 1, 0, 0, 7);
    tick();
    alu_instr(ADD, 8, 5, 0, 0, 0, 0, 0);
    rd_w = 5; RegWrite_w = 1; Result_w = 100;
    tick();
    total++;
    if (ALUResult_m !== 32'd7) begin
      bad++; $display("FAIL mem_over_wb got=%0d exp=7", ALUResult_m);
    end
    // MEM now holds x8, so only WB matches x5
    alu_instr(ADD, 9, 5, 0, 0, 0, 0, 0);
    rd_w = 5; RegWrite_w = 1; Result_w = 100;
    tick();
    total++;
    if (ALUResult_m !== 32'd100) begin
      bad++; $display("FAIL wb_fwd got=%0d exp=100", ALUResult_m);
    end
    clr();
    alu_instr(ADD, 0, 0, 0, 1, 0, 0, 7);
    tick();
    alu_instr(ADD, 10, 0, 0, 0, 32'h55, 0, 0);
    rd_w = 0; RegWrite_w = 1; Result_w = 100;
    tick();
    total++;
    if (ALUResult_m !== 32'h55) begin
      bad++; $display("FAIL x0_nofwd got=%h exp=%h", ALUResult_m, 32'h55);
    end
    clr();
    alu_instr(ADD, 5, 0, 0, 1, 0, 0, 7);
    ResultSrc_e = RES_LOAD;
    tick();
    alu_instr(ADD, 11, 5, 0, 0, 32'h33, 0, 0);
    tick();
    total++;
    if (ALUResult_m !== 32'h33) begin
      bad++; $display("FAIL load_nofwd got=%h exp=%h", ALUResult_m, 32'h33);
    end
    clr(); tick();
  endtask

  task automatic test_branch();
    clr(); tick();
    valid_e = 1; Branch_e = 1; funct3_e = F3_BLT;
    rs1_e = 1; rs2_e = 2; RD1_e = 32'hFFFF_FFFF; RD2_e = 1;
    PC_e = 32'h200; ImmOp_e = 32'h40; ALUsrc_e = 1;
    #1;
    total++;
    if (PCSrc_e !== 1'b1 || PCTarget_e !== 32'h240) begin
      bad++;
      $display("FAIL blt got=%b/%h exp=1/%h", PCSrc_e, PCTarget_e, 32'h240);
    end
    funct3_e = F3_BLTU;
    #1;
    total++;
    if (PCSrc_e !== 1'b0) begin
      bad++; $display("FAIL bltu got=%b exp=0", PCSrc_e);
    end
    funct3_e = F3_BNE;
    flush_e = 1;
    #1;
    total++;
    if (PCSrc_e !== 1'b0) begin
      bad++; $display("FAIL flushed_br got=%b exp=0", PCSrc_e);
    end
    clr();
    valid_e = 1; Jump_e = 1; JALRctrl_e = 1;
    rs1_e = 1; RD1_e = 32'h1001; ImmOp_e = 4; PC_e = 32'h300;
    #1;
    total++;
    if (PCSrc_e !== 1'b1 || PCTarget_e !== 32'h1004) begin
      bad++;
      $display("FAIL jalr got=%b/%h exp=1/%h",
               PCSrc_e, PCTarget_e, 32'h1004);
    end
    clr(); tick();
  endtask

  task automatic test_mul();
    clr(); tick();
    alu_instr(MUL, 10, 1, 2, 0, 32'h0001_0003, 5, 0);
    #1;
    total++;
    if (busy_e !== 1'b1) begin
      bad++; $display("FAIL mul_busy0 got=%b exp=1", busy_e);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd_w = 1; RegWrite_w = 1; Result_w = 32'hDEAD;
      #1;
      total++;
      if (valid_m !== 1'b0) begin
        bad++; $display("FAIL mul_bubble%0d got=%b exp=0", i, valid_m);
      end
      total++;
      if (busy_e !== (i < 4)) begin
        bad++;
        $display("FAIL mul_busy%0d got=%b exp=%b", i, busy_e, i < 4);
      end
    end
    tick();
    total++;
    if (valid_m !== 1'b1 || ALUResult_m !== 32'h0005_000F ||
        rd_m !== 5'd10) begin
      bad++;
      $display("FAIL mul_result got=%b/%h/%0d exp=1/%h/10",
               valid_m, ALUResult_m, rd_m, 32'h0005_000F);
    end
    // same MUL held in EX again starts a fresh count
    total++;
    if (busy_e !== 1'b1) begin
      bad++; $display("FAIL mul_b2b got=%b exp=1", busy_e);
    end
    flush_e = 1;
    tick();
    clr(); tick();
  endtask

  task automatic test_flush();
    int n;
    clr(); tick();
    alu_instr(MUL, 12, 1, 2, 0, 6, 7, 0);
    #1;
    tick();
    total++;
    if (busy_e !== 1'b1) begin
      bad++; $display("FAIL fl_busy1 got=%b exp=1", busy_e);
    end
    tick();
    flush_e = 1;
    #1;
    total++;
    if (busy_e !== 1'b0) begin
      bad++; $display("FAIL fl_busy got=%b exp=0", busy_e);
    end
    tick();
    total++;
    if (valid_m !== 1'b0 || RegWrite_m !== 1'b0) begin
      bad++;
      $display("FAIL fl_bubble got=%b%b exp=00", valid_m, RegWrite_m);
    end
    flush_e = 0;
    alu_instr(ADD, 11, 1, 2, 0, 3, 4, 0);
    tick();
    total++;
    if (valid_m !== 1'b1 || ALUResult_m !== 32'd7 || rd_m !== 5'd11) begin
      bad++;
      $display("FAIL fl_next got=%b/%0d/%0d exp=1/7/11",
               valid_m, ALUResult_m, rd_m);
    end
    alu_instr(MUL, 12, 1, 2, 0, 6, 7, 0);
    #1;
    n = 0;
    while (busy_e && n < 10) begin
      n++;
      tick();
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL fl_recount got=%0d exp=4", n);
    end
    tick();
    total++;
    if (ALUResult_m !== 32'd42 || valid_m !== 1'b1) begin
      bad++;
      $display("FAIL fl_mul got=%0d/%b exp=42/1", ALUResult_m, valid_m);
    end
    clr(); tick();
  endtask

  initial begin
    clr();
    test_reset();
    test_mem_fwd();
    test_priority();
    test_branch();
    test_mul();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
